// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, synchronous-read unified memory between
// the instruction-fetch port and the load/store port of the core.
//
// Grants at most one access per cycle. Data wins over fetch. Read data returns
// one cycle after the grant and is routed to the port that issued the read.
// Synchronous active-high reset.
//
// Optional build macro: MEM_ARB_STARVE_GUARD_EN
//   Defined   : a saturating counter tracks consecutive denied fetch cycles.
//               When it reaches STARVE_MAX, the pending fetch is granted even
//               if a data request is present.
//   Undefined : strict data priority. Fetch may starve indefinitely.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   if_req_i, if_addr_i        fetch request, word address
//   if_gnt_o, if_stall_o       fetch accepted / fetch pending but denied
//   if_rvalid_o, if_rdata_o    fetch response (cycle after if_gnt_o)
//   d_req_i, d_we_i, d_addr_i  data request, store flag, byte address
//   d_wdata_i, d_be_i          store data, byte enables
//   d_gnt_o                    data access accepted
//   d_rvalid_o, d_rdata_o      load response (cycle after load grant)
//   mem_en_o .. mem_be_o       memory macro drive
//   mem_rdata_i                memory read data (cycle after read strobe)

module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-3:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [31:0]       mem_rdata_i
);

  // Elaboration-time parameter sanity check.
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

  // Read-response owner: who issued the read granted in the previous cycle.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic [1:0] owner_q, owner_d;
  logic       force_if;
  logic       if_gnt, d_gnt;

  // Byte offset of the data address is intentionally ignored.
  logic unused_d_addr_lsb;
  assign unused_d_addr_lsb = ^d_addr_i[1:0];

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;

  assign force_if = if_req_i && (starve_q == STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grant decision is purely combinational on this cycle's requests.
  assign d_gnt  = !rst_i && d_req_i && !force_if;
  assign if_gnt = !rst_i && if_req_i && (!d_req_i || force_if);

  assign d_gnt_o    = d_gnt;
  assign if_gnt_o   = if_gnt;
  assign if_stall_o = !rst_i && if_req_i && !if_gnt;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'd0;
    mem_be_o    = 4'h0;
    if (d_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i[ADDR_W-1:2];
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_be_i;
    end else if (if_gnt) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = if_addr_i;
      mem_be_o    = 4'hF;
    end
  end

  // Stores complete at grant and produce no response.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we_i) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Gating with rst_i kills a response whose grant preceded reset assertion.
  assign if_rvalid_o = !rst_i && (owner_q == OWN_IF);
  assign d_rvalid_o  = !rst_i && (owner_q == OWN_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'd0;
  assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [29:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o, if_stall_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  // Behavioural single-port synchronous-read memory.
  logic [31:0] mem [256];

  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o[7:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= mem[mem_addr_o[7:0]];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [29:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_if_stall;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [29:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic [3:0]  e_mem_be;
    logic        e_if_rvalid;
    logic [31:0] e_if_rdata;
    logic        e_d_rvalid;
    logic [31:0] e_d_rdata;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic ir, input logic [29:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] dbe);
    rst_i = r; if_req_i = ir; if_addr_i = ia;
    d_req_i = dr; d_we_i = dw; d_addr_i = da; d_wdata_i = dwd; d_be_i = dbe;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic exp_if, input logic exp_d);
    chk({tag, ".if_rvalid"}, {31'd0, if_rvalid_o}, {31'd0, exp_if});
    chk({tag, ".d_rvalid"},  {31'd0, d_rvalid_o},  {31'd0, exp_d});
    chk({tag, ".if_rdata"},  if_rdata_o, exp_if ? 32'h01020304 : 32'h0);
    chk({tag, ".d_rdata"},   d_rdata_o,  exp_d  ? 32'hCAFECC0D : 32'h0);
  endtask

  initial begin
    bit prev_ig, prev_dg, prev_ld;
    string tag;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h00500093;
    mem[8'h11] = 32'hCAFEF00D;
    mem[8'h20] = 32'h11112222;
    mem[8'h30] = 32'h30303030;
    mem_rdata_i = 32'h0;

    //         rst ir ia     dr dw da      dwd           dbe | ig dg st en we maddr  mwd           mbe | irv ird           drv drd
    tbl[0]  = '{1, 1, 'h10,  1, 0, 'h44,   'h0,          'hF,  0, 0, 0, 0, 0, 'h0,  'h0,          'h0,  0, 'h0,          0, 'h0};
    tbl[1]  = '{0, 0, 'h0,   0, 0, 'h0,    'h0,          'h0,  0, 0, 0, 0, 0, 'h0,  'h0,          'h0,  0, 'h0,          0, 'h0};
    tbl[2]  = '{0, 1, 'h10,  0, 0, 'h0,    'h0,          'h0,  1, 0, 0, 1, 0, 'h10, 'h0,          'hF,  0, 'h0,          0, 'h0};
    tbl[3]  = '{0, 0, 'h0,   0, 0, 'h0,    'h0,          'h0,  0, 0, 0, 0, 0, 'h0,  'h0,          'h0,  1, 'h00500093,   0, 'h0};
    tbl[4]  = '{0, 0, 'h0,   1, 1, 'h40,   'hDEADBEEF,   'hF,  0, 1, 0, 1, 1, 'h10, 'hDEADBEEF,   'hF,  0, 'h0,          0, 'h0};
    tbl[5]  = '{0, 0, 'h0,   1, 0, 'h40,   'h12345678,   'h3,  0, 1, 0, 1, 0, 'h10, 'h12345678,   'h3,  0, 'h0,          0, 'h0};
    tbl[6]  = '{0, 1, 'h20,  1, 0, 'h44,   'h0,          'hF,  0, 1, 1, 1, 0, 'h11, 'h0,          'hF,  0, 'h0,          1, 'hDEADBEEF};
    tbl[7]  = '{0, 1, 'h20,  0, 0, 'h0,    'h0,          'h0,  1, 0, 0, 1, 0, 'h20, 'h0,          'hF,  0, 'h0,          1, 'hCAFEF00D};
    tbl[8]  = '{0, 0, 'h0,   0, 0, 'h0,    'h0,          'h0,  0, 0, 0, 0, 0, 'h0,  'h0,          'h0,  1, 'h11112222,   0, 'h0};
    tbl[9]  = '{0, 0, 'h0,   1, 1, 'h47,   'hAABBCCDD,   'h2,  0, 1, 0, 1, 1, 'h11, 'hAABBCCDD,   'h2,  0, 'h0,          0, 'h0};
    tbl[10] = '{0, 1, 'h30,  1, 1, 'h80,   'h55,         'h1,  0, 1, 1, 1, 1, 'h20, 'h55,         'h1,  0, 'h0,          0, 'h0};
    tbl[11] = '{0, 1, 'h30,  1, 0, 'h44,   'h0,          'hF,  0, 1, 1, 1, 0, 'h11, 'h0,          'hF,  0, 'h0,          0, 'h0};
    tbl[12] = '{0, 1, 'h30,  0, 0, 'h0,    'h0,          'h0,  1, 0, 0, 1, 0, 'h30, 'h0,          'hF,  0, 'h0,          1, 'hCAFECC0D};
    tbl[13] = '{0, 0, 'h0,   1, 0, 'h80,   'h0,          'hF,  0, 1, 0, 1, 0, 'h20, 'h0,          'hF,  1, 'h30303030,   0, 'h0};
    tbl[14] = '{0, 1, 'h10,  0, 0, 'h0,    'h0,          'h0,  1, 0, 0, 1, 0, 'h10, 'h0,          'hF,  0, 'h0,          1, 'h11112255};
    tbl[15] = '{0, 0, 'h0,   1, 1, 'h40,   'h01020304,   'hF,  0, 1, 0, 1, 1, 'h10, 'h01020304,   'hF,  1, 'hDEADBEEF,   0, 'h0};
    tbl[16] = '{0, 1, 'h10,  0, 0, 'h0,    'h0,          'h0,  1, 0, 0, 1, 0, 'h10, 'h0,          'hF,  0, 'h0,          0, 'h0};
    tbl[17] = '{1, 1, 'h10,  0, 0, 'h0,    'h0,          'h0,  0, 0, 0, 0, 0, 'h0,  'h0,          'h0,  0, 'h0,          0, 'h0};
    tbl[18] = '{1, 0, 'h0,   1, 0, 'h44,   'h0,          'hF,  0, 0, 0, 0, 0, 'h0,  'h0,          'h0,  0, 'h0,          0, 'h0};
    tbl[19] = '{0, 0, 'h0,   0, 0, 'h0,    'h0,          'h0,  0, 0, 0, 0, 0, 'h0,  'h0,          'h0,  0, 'h0,          0, 'h0};
    tbl[20] = '{0, 1, 'h10,  0, 0, 'h0,    'h0,          'h0,  1, 0, 0, 1, 0, 'h10, 'h0,          'hF,  0, 'h0,          0, 'h0};
    tbl[21] = '{0, 0, 'h0,   0, 0, 'h0,    'h0,          'h0,  0, 0, 0, 0, 0, 'h0,  'h0,          'h0,  1, 'h01020304,   0, 'h0};

    set_in(1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      tick();
      set_in(tbl[i].rst, tbl[i].if_req, tbl[i].if_addr, tbl[i].d_req, tbl[i].d_we,
             tbl[i].d_addr, tbl[i].d_wdata, tbl[i].d_be);
      #4;
      tag = $sformatf("v%0d", i);
      chk({tag, ".if_gnt"},    {31'd0, if_gnt_o},    {31'd0, tbl[i].e_if_gnt});
      chk({tag, ".d_gnt"},     {31'd0, d_gnt_o},     {31'd0, tbl[i].e_d_gnt});
      chk({tag, ".if_stall"},  {31'd0, if_stall_o},  {31'd0, tbl[i].e_if_stall});
      chk({tag, ".mem_en"},    {31'd0, mem_en_o},    {31'd0, tbl[i].e_mem_en});
      chk({tag, ".mem_we"},    {31'd0, mem_we_o},    {31'd0, tbl[i].e_mem_we});
      chk({tag, ".mem_addr"},  {2'd0, mem_addr_o},   {2'd0, tbl[i].e_mem_addr});
      chk({tag, ".mem_wdata"}, mem_wdata_o,          tbl[i].e_mem_wdata);
      chk({tag, ".mem_be"},    {28'd0, mem_be_o},    {28'd0, tbl[i].e_mem_be});
      chk({tag, ".if_rvalid"}, {31'd0, if_rvalid_o}, {31'd0, tbl[i].e_if_rvalid});
      chk({tag, ".if_rdata"},  if_rdata_o,           tbl[i].e_if_rdata);
      chk({tag, ".d_rvalid"},  {31'd0, d_rvalid_o},  {31'd0, tbl[i].e_d_rvalid});
      chk({tag, ".d_rdata"},   d_rdata_o,            tbl[i].e_d_rdata);
    end

    // Memory now: word 0x10 = 0x01020304, word 0x11 = 0xCAFECC0D.
    // Continuous contention: fetch 0x10 vs load 0x44 for 10 cycles.
    prev_ig = 0; prev_dg = 0;
    for (int i = 0; i < 10; i++) begin
      bit ig;
`ifdef MEM_ARB_STARVE_GUARD_EN
      ig = (i % 5) == 4;
`else
      ig = 1'b0;
`endif
      tick();
      set_in(0, 1, 30'h10, 1, 0, 32'h44, 32'h0, 4'hF);
      #4;
      tag = $sformatf("starve%0d", i);
      chk({tag, ".if_gnt"},   {31'd0, if_gnt_o},   {31'd0, ig});
      chk({tag, ".d_gnt"},    {31'd0, d_gnt_o},    {31'd0, !ig});
      chk({tag, ".if_stall"}, {31'd0, if_stall_o}, {31'd0, !ig});
      chk({tag, ".mem_addr"}, {2'd0, mem_addr_o},  ig ? 32'h10 : 32'h11);
      chk_resp(tag, prev_ig, prev_dg);
      prev_ig = ig; prev_dg = !ig;
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk_resp("starve_tail", prev_ig, prev_dg);

    // Back-to-back: fetch on even cycles; odd cycles alternate load 0x44 / store 0x48.
    prev_ig = 0; prev_ld = 0;
    for (int i = 0; i < 8; i++) begin
      bit ig, ld;
      ig = (i % 2) == 0;
      ld = (i % 4) == 1;
      tick();
      if (ig) set_in(0, 1, 30'h10, 0, 0, 0, 0, 0);
      else if (ld) set_in(0, 0, 0, 1, 0, 32'h44, 32'h0, 4'hF);
      else set_in(0, 0, 0, 1, 1, 32'h48, 32'hA5A50000 | 32'(i), 4'hF);
      #4;
      tag = $sformatf("b2b%0d", i);
      chk({tag, ".if_gnt"}, {31'd0, if_gnt_o}, {31'd0, ig});
      chk({tag, ".d_gnt"},  {31'd0, d_gnt_o},  {31'd0, !ig});
      chk({tag, ".mem_we"}, {31'd0, mem_we_o}, {31'd0, !ig && !ld});
      chk_resp(tag, prev_ig, prev_ld);
      prev_ig = ig; prev_ld = ld;
    end
    tick();
    set_in(0, 0, 0, 1, 0, 32'h48, 32'h0, 4'hF);
    #4;
    chk_resp("b2b_tail", prev_ig, prev_ld);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("b2b_last_store.d_rvalid", {31'd0, d_rvalid_o}, 32'd1);
    chk("b2b_last_store.d_rdata",  d_rdata_o, 32'hA5A50007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, synchronous-read unified memory between the core's instruction-fetch port and its load/store port.
- Grants at most one access per cycle, with data priority over fetch, and returns read data one cycle after the grant.
- Routes each read response back to the requester that issued it.
- Sits between hp_core's fetch/LSU ports and the unified memory macro; `if_stall` feeds PC hold logic.

Parameters:
- ADDR_W, 32: byte-address width of the data port; memory word address is ADDR_W-2 bits.
- STARVE_MAX, 4: consecutive denied fetch cycles before the starvation guard forces a fetch grant (guard build only; legal range 1..15).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W-2  fetch word address (PC without low 2 bits).
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid (cycle after if_gnt).
- if_rdata  out  32  fetch data.
- if_stall  out  1  if_req & ~if_gnt.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address; bits [1:0] are ignored.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid (cycle after load grant).
- d_rdata  out  32  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W-2  memory word address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- Grant decision is combinational in the request cycle.
  - d_req=1 → d_gnt=1, if_gnt=0 (unless the guard overrides).
  - else if_req=1 → if_gnt=1.
  - No requests → no grant.
- Memory drive on a data grant: mem_en=1, mem_we=d_we, mem_addr=d_addr[ADDR_W-1:2], mem_wdata=d_wdata, mem_be=d_be.
- Memory drive on a fetch grant: mem_en=1, mem_we=0, mem_addr=if_addr, mem_be=4'hF, mem_wdata=0.
- With no grant: mem_en=0, mem_we=0, mem_be=0, mem_addr and mem_wdata=0.
- Requester handshake: hold req, addr, wdata and be stable until gnt is seen; the arbiter does not latch the request itself.
- Response routing register `owner` ∈ {NONE, IF, D}:
  - Next value = IF on a fetch grant, D on a load grant, NONE otherwise (stores and idle).
- Response outputs are driven the cycle after the grant:
  - if_rvalid = (owner==IF), d_rvalid = (owner==D).
  - if_rdata and d_rdata are both mem_rdata, gated to 0 when the matching rvalid is low.
- Latency:
  - Load/fetch: grant in cycle N, rvalid and data in cycle N+1.
  - Store: completes at grant with no rvalid.
  - Back-to-back grants are allowed every cycle (full throughput).
- Simultaneous requests: the loser stays pending and gets if_stall=1; no state is kept for it beyond the starvation counter.
- A new grant in cycle N+1 does not disturb the response for the grant in cycle N.
- Reset: owner=NONE and the starvation counter clears to 0.
  - During rst all grants, mem_en and rvalids are forced to 0.
  - A read granted in the cycle before rst is asserted produces no rvalid.
  - Requests are ignored while rst=1.
- Word addressing: the arbiter does no alignment checks; misalignment is the LSU's responsibility.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments each cycle that if_req=1 and if_gnt=0, saturating at STARVE_MAX.
  - When count==STARVE_MAX and if_req=1, the fetch wins that cycle even if d_req=1; d_gnt=0 and the data requester waits.
  - The counter clears on any fetch grant, on any cycle with if_req=0, and on rst.
- Undefined: strict data priority with no counter logic; fetch may starve indefinitely.

Test Plan:
- Fetch only: if_req=1, if_addr=0x10, memory word 0x10=0x00500093 → if_gnt=1 in cycle N, if_rvalid=1 with if_rdata=0x00500093 in N+1, mem_addr=0x10, mem_we=0.
- Store then load: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'hF → d_gnt=1, no d_rvalid. Next cycle load 0x40 → d_rvalid=1 with d_rdata=0xDEADBEEF one cycle later; mem_addr=0x10.
- Conflict: if_req and d_req (load at 0x44) both high in one cycle → d_gnt=1, if_gnt=0, if_stall=1. Next cycle d_req=0 → if_gnt=1. Responses arrive in grant order with the correct rvalid for each.
- Reset mid-read: fetch granted in cycle N, rst=1 in N+1 → if_rvalid=0 in N+1, all outputs 0 while rst is held, owner=NONE after release.
- Guard (macro defined, STARVE_MAX=4): d_req and if_req held high continuously → d_gnt for 4 cycles, then if_gnt in the 5th, then data resumes. Macro undefined → if_gnt never asserts.
- Back-to-back: alternate fetch/load grants every cycle for 8 cycles → exactly one rvalid per read grant, one cycle late, and no rvalid on either port for stores.
